// File: rtl/control_barra_porcentaje_pkg.sv
// Shared constants for the percentage bar sequencer: value width, FSM encodings, counter sizing.
package control_barra_porcentaje_pkg;

  localparam int PCT_W = 7;

  localparam logic [0:0] REPOSO   = 1'b0;
  localparam logic [0:0] ANIMANDO = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clogb2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/control_barra_porcentaje_if.sv
// Button/frame inputs and duty/display outputs of the percentage bar sequencer.
interface control_barra_porcentaje_if;
  import control_barra_porcentaje_pkg::*;

  logic             btn_up;
  logic             btn_down;
  logic             fin_frame;
  logic [PCT_W-1:0] duty;
  logic [PCT_W-1:0] porcentaje;
  logic             ocupado;

  modport master (
    output btn_up, btn_down, fin_frame,
    input  duty, porcentaje, ocupado
  );

  modport slave (
    input  btn_up, btn_down, fin_frame,
    output duty, porcentaje, ocupado
  );

endinterface

// File: rtl/control_barra_porcentaje_detector_flanco_pulsador.sv
// Rising-edge press detector for one debounced button; with AUTOREPETICION_EN a held
// button also yields a press every FRAMES_REPETICION frames.
module detector_flanco_pulsador
  import control_barra_porcentaje_pkg::*;
#(
  parameter int FRAMES_REPETICION = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
`ifdef AUTOREPETICION_EN
  input  logic otro_i,
  input  logic fin_frame_i,
`endif
  output logic pulso_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn_i;
  end

`ifdef AUTOREPETICION_EN
  localparam int REP_W = clogb2(FRAMES_REPETICION);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             repetir;

  // Counting starts the cycle after the edge; release or a chord resets it.
  always_comb begin
    rep_d   = rep_q;
    repetir = 1'b0;
    if (!btn_i || otro_i || !prev_q) begin
      rep_d = '0;
    end else if (fin_frame_i) begin
      if (rep_q == REP_W'(FRAMES_REPETICION - 1)) begin
        rep_d   = '0;
        repetir = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end

  assign pulso_o = (btn_i & ~prev_q) | repetir;
`else
  assign pulso_o = btn_i & ~prev_q;
`endif

endmodule

// File: rtl/control_barra_porcentaje.sv
// Target percentage from up/down presses (drives PWM at once) and a display value that walks
// 1 % toward it every FRAMES_POR_PASO vertical blanks. AUTOREPETICION_EN enables hold-to-repeat.
module control_barra_porcentaje
  import control_barra_porcentaje_pkg::*;
#(
  parameter int PASO            = 5,
  parameter int PCT_MAX         = 100,
  parameter int FRAMES_POR_PASO = 2,
  parameter int PCT_RESET       = 0
`ifdef AUTOREPETICION_EN
  ,
  parameter int FRAMES_REPETICION = 30
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  control_barra_porcentaje_if.slave    bus
);

  localparam int SUM_W = PCT_W + 1;
  localparam int CNT_W = clogb2(FRAMES_POR_PASO);

  logic             pulso_up, pulso_down;
  logic [PCT_W-1:0] obj_q, obj_d;
  logic [PCT_W-1:0] pct_q, pct_d, pct_paso;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       estado_q, estado_d;
  logic [SUM_W-1:0] suma;

`ifdef AUTOREPETICION_EN
  detector_flanco_pulsador #(.FRAMES_REPETICION(FRAMES_REPETICION)) u_det_up (
    .clk(clk), .rst(rst), .btn_i(bus.btn_up), .otro_i(bus.btn_down),
    .fin_frame_i(bus.fin_frame), .pulso_o(pulso_up)
  );
  detector_flanco_pulsador #(.FRAMES_REPETICION(FRAMES_REPETICION)) u_det_down (
    .clk(clk), .rst(rst), .btn_i(bus.btn_down), .otro_i(bus.btn_up),
    .fin_frame_i(bus.fin_frame), .pulso_o(pulso_down)
  );
`else
  detector_flanco_pulsador u_det_up (
    .clk(clk), .rst(rst), .btn_i(bus.btn_up), .pulso_o(pulso_up)
  );
  detector_flanco_pulsador u_det_down (
    .clk(clk), .rst(rst), .btn_i(bus.btn_down), .pulso_o(pulso_down)
  );
`endif

  // Sum is one bit wider so obj+PASO cannot wrap before the saturation test.
  always_comb begin
    suma  = {1'b0, obj_q} + SUM_W'(PASO);
    obj_d = obj_q;
    if (pulso_up && !pulso_down) begin
      obj_d = (suma > SUM_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : suma[PCT_W-1:0];
    end else if (pulso_down && !pulso_up) begin
      obj_d = ({1'b0, obj_q} >= SUM_W'(PASO)) ? obj_q - PCT_W'(PASO) : '0;
    end
  end

  always_comb begin
    pct_d    = pct_q;
    cnt_d    = cnt_q;
    estado_d = estado_q;
    pct_paso = (pct_q < obj_q) ? pct_q + PCT_W'(1) : pct_q - PCT_W'(1);
    case (estado_q)
      REPOSO: begin
        cnt_d = '0;
        if (pct_q != obj_q) estado_d = ANIMANDO;
      end
      ANIMANDO: begin
        if (pct_q == obj_q) begin
          estado_d = REPOSO;
          cnt_d    = '0;
        end else if (bus.fin_frame) begin
          // Step direction comes from the registered target, so a same-cycle press applies later.
          if (cnt_q == CNT_W'(FRAMES_POR_PASO - 1)) begin
            cnt_d = '0;
            pct_d = pct_paso;
            if (pct_paso == obj_q) estado_d = REPOSO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        estado_d = REPOSO;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_q    <= PCT_W'(PCT_RESET);
      pct_q    <= PCT_W'(PCT_RESET);
      cnt_q    <= '0;
      estado_q <= REPOSO;
    end else begin
      obj_q    <= obj_d;
      pct_q    <= pct_d;
      cnt_q    <= cnt_d;
      estado_q <= estado_d;
    end
  end

  assign bus.duty       = obj_q;
  assign bus.porcentaje = pct_q;
  assign bus.ocupado    = (pct_q != obj_q);

endmodule

// File: doc/control_barra_porcentaje.md
Name: control_barra_porcentaje

Overview:
- Sequencer for the LCD percentage bar and the PWM duty value.
- Turns debounced up/down button levels into a target percentage, `obj`, in the range 0..100. `obj` drives the PWM duty immediately.
- Moves the displayed percentage toward `obj` by 1 % per animation step, only at vertical blank, so the bar never tears mid-frame.
- Sits between the button debouncers / VGA-LCD timing generator and the bar renderer / PWM generator.

Parameters:
- PASO, 5, percent added/removed per button press (1..100).
- PCT_MAX, 100, upper saturation limit for target and display.
- FRAMES_POR_PASO, 2, frames between successive 1 % display steps (>=1).
- PCT_RESET, 0, value loaded into target and display on reset (<= PCT_MAX).
- FRAMES_REPETICION, 30, frames a button must be held before and between auto-repeats (only with AUTOREPETICION_EN).

Ports:
- clk  input  1  system clock (pixel clock domain).
- rst  input  1  asynchronous active-high reset.
- btn_up  input  1  debounced level, synchronous to clk.
- btn_down  input  1  debounced level, synchronous to clk.
- fin_frame  input  1  one-cycle pulse at start of vertical blank.
- duty  output  7  target percentage (`obj`), to PWM generator.
- porcentaje  output  7  displayed percentage, to bar renderer.
- ocupado  output  1  high while porcentaje != duty.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. All state is cleared on rst assertion, independent of clk.
- Reset values:
  - duty = PCT_RESET, porcentaje = PCT_RESET, ocupado = 0.
  - Frame counter = 0, button history registers = 0, FSM = REPOSO.
- Edge detect: a press is the rising edge of btn_* (registered previous level). Each button therefore needs a 0->1 transition after reset to count.
- Target update, registered, visible on duty one cycle after the edge cycle:
  - up only: obj = min(obj+PASO, PCT_MAX).
  - down only: obj = max(obj-PASO, 0).
  - Both edges in the same cycle: no change.
  - Compute in 8 bits to avoid overflow before saturating; the result is 7 bits.
- FSM states REPOSO and ANIMANDO:
  - REPOSO: porcentaje == duty, frame counter held at 0. When porcentaje != duty, go to ANIMANDO.
  - ANIMANDO: on each fin_frame, the counter increments.
    - When counter == FRAMES_POR_PASO-1 on a fin_frame: counter <- 0, porcentaje steps 1 toward duty.
    - If after that step porcentaje == duty, go to REPOSO.
- Display never changes outside a fin_frame cycle.
- ocupado is combinational from the registers: porcentaje != duty.
- Target changes while animating:
  - Animation retargets without restarting the counter.
  - If the target crosses back past porcentaje, the direction reverses on the next step.
  - If duty becomes equal to porcentaje between frames, go to REPOSO on the next clk; the counter clears.
- A button edge and fin_frame in the same cycle: the step uses the old duty; the new duty applies from the next cycle.
- Saturation: presses at 100 (up) or 0 (down) leave duty unchanged and do not enter ANIMANDO.
- rst asserted mid-animation: immediate return to the reset values.

Optional Feature:
- Macro: AUTOREPETICION_EN.
- Defined: a held button (level high, other button low) generates an extra press every FRAMES_REPETICION fin_frame pulses after the initial edge. A per-button repeat counter handles this; it is cleared on release or when both buttons are high.
- Undefined: only rising edges count; holding has no further effect, and the repeat counter logic is absent.

Decomposition:
- Shared package/header (MathFun.vh style include):
  - CLogB2 for counter widths.
  - FSM state encodings REPOSO = 1'b0, ANIMANDO = 1'b1.
  - PCT_W = 7.
- One sub-module, `detector_flanco_pulsador`: rising-edge detection and, under AUTOREPETICION_EN, the repeat counter. It is instantiated twice, once per button.

Test Plan:
- Reset release with defaults -> duty = 0, porcentaje = 0, ocupado = 0.
- One btn_up edge -> duty = 5 next cycle, ocupado = 1. porcentaje reaches 1, 2, 3, 4, 5 on fin_frame pulses 2, 4, 6, 8, 10. ocupado = 0 after the 10th.
- 21 btn_up presses -> duty saturates at 100. A further press leaves duty = 100; once the display has settled, ocupado stays 0.
- btn_up and btn_down edges in the same cycle at duty = 50 -> duty stays 50, no animation.
- At porcentaje = 3, duty = 5, press btn_down twice (duty = 0 after the second) -> porcentaje steps 3 -> 2 -> 1 -> 0 without overshoot; a fin_frame coinciding with an edge uses the old duty.
- AUTOREPETICION_EN: hold btn_up for 95 frames from 0 -> duty = 5 (edge), then 10, 15, 20 at frames 30, 60, 90. Release clears the repeat counter; rst mid-hold restores 0 / 0 / 0.
